// File: rtl/rf_arb_rr_if.sv
// Bus bundle between the requesters + RAM macro (master side) and the
// round-robin register-file arbiter (slave side).
//   req_valid/req_ready/req_write : per-requester handshake and op select
//   req_addr/req_wben/req_wdata   : per-requester address, byte enables, data
//   resp_valid/resp_rdata         : one-hot read return, shared data bus
//   ram_write/ram_addr/ram_wben/ram_din : single-port RAM command
//   ram_dout                      : RAM read data (one cycle after address)
interface rf_arb_rr_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 2
);
  localparam int unsigned DLG2   = $clog2(DEPTH);
  localparam int unsigned NBYTES = WIDTH / 8;

  logic [NREQ-1:0]              req_valid;
  logic [NREQ-1:0]              req_ready;
  logic [NREQ-1:0]              req_write;
  logic [NREQ-1:0][DLG2-1:0]    req_addr;
  logic [NREQ-1:0][NBYTES-1:0]  req_wben;
  logic [NREQ-1:0][WIDTH-1:0]   req_wdata;
  logic [NREQ-1:0]              resp_valid;
  logic [WIDTH-1:0]             resp_rdata;
  logic                         ram_write;
  logic [DLG2-1:0]              ram_addr;
  logic [NBYTES-1:0]            ram_wben;
  logic [WIDTH-1:0]             ram_din;
  logic [WIDTH-1:0]             ram_dout;

  // Requesters and the RAM model sit on this side.
  modport master (
    output req_valid, req_write, req_addr, req_wben, req_wdata, ram_dout,
    input  req_ready, resp_valid, resp_rdata,
    input  ram_write, ram_addr, ram_wben, ram_din
  );

  // The arbiter sits on this side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wben, req_wdata, ram_dout,
    output req_ready, resp_valid, resp_rdata,
    output ram_write, ram_addr, ram_wben, ram_din
  );
endinterface

// File: rtl/rf_arb_rr.sv
// Round-robin arbiter sharing one single-port byte-enable register-file RAM
// among NREQ requesters, with bounded grant hold (bursts) and one-cycle read
// return routed to the issuing requester.
//   eph1    : clock, all state updates on its rising edge
//   reset_n : synchronous active-low reset
//   bus     : request/response/RAM bundle (slave modport)
module rf_arb_rr #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREQ     = 2,
  parameter int unsigned MAXBURST = 4
) (
  input  logic        eph1,
  input  logic        reset_n,
  rf_arb_rr_if.slave  bus
);
  localparam int unsigned DLG2   = $clog2(DEPTH);
  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW     = $clog2(MAXBURST + 1);

  // Architectural state
  logic [PW-1:0]   prio_q,    prio_d;
  logic [PW-1:0]   owner_q,   owner_d;
  logic [BW-1:0]   burst_q,   burst_d;
  logic [NREQ-1:0] resp_id_q, resp_id_d;

  // Grant decode results
  logic [NREQ-1:0]   live;
  logic              hold;
  logic              accept;
  logic [PW-1:0]     gnt_id;
  logic [NREQ-1:0]   gnt_oh;
  logic              gnt_write;
  logic [DLG2-1:0]   gnt_addr;
  logic [NBYTES-1:0] gnt_wben;
  logic [WIDTH-1:0]  gnt_wdata;

  // State register
  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      prio_q    <= '0;
      owner_q   <= '0;
      burst_q   <= '0;
      resp_id_q <= '0;
    end else begin
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      resp_id_q <= resp_id_d;
    end
  end

  // Grant: hold the burst owner while the burst is open, else rotate from prio.
  // Reset masks the requests so nothing is accepted while reset_n is low.
  always_comb begin : grant_pick
    int unsigned idx;
    live      = bus.req_valid & {NREQ{reset_n}};
    hold      = (burst_q != '0) && (burst_q < BW'(MAXBURST)) && live[owner_q];
    accept    = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    if (hold) begin
      accept = 1'b1;
      gnt_id = owner_q;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = 32'(prio_q) + i;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end
        if (!accept && live[PW'(idx)]) begin
          accept = 1'b1;
          gnt_id = PW'(idx);
        end
      end
    end
    gnt_oh    = accept ? (NREQ'(1) << gnt_id) : '0;
    gnt_write = accept & bus.req_write[gnt_id];
    gnt_addr  = bus.req_addr[gnt_id];
    gnt_wben  = bus.req_wben[gnt_id];
    gnt_wdata = bus.req_wdata[gnt_id];
  end

  // Next state: burst bookkeeping, pointer rotation, read-return tag
  always_comb begin : next_state
    prio_d    = prio_q;
    owner_d   = owner_q;
    burst_d   = '0;
    resp_id_d = '0;
    if (accept) begin
      if ((gnt_id == owner_q) && (burst_q != '0)) begin
        // Owner re-winning an exhausted burst (nobody else valid) stays pinned
        // at MAXBURST so hold remains off and every cycle keeps re-arbitrating.
        burst_d = (burst_q == BW'(MAXBURST)) ? burst_q : burst_q + BW'(1);
      end else begin
        burst_d = BW'(1);
        owner_d = gnt_id;
      end
      prio_d = ((32'(gnt_id) + 32'd1) >= NREQ) ? '0 : gnt_id + PW'(1);
      if (!gnt_write) begin
        resp_id_d = gnt_oh;
      end
    end
  end

  // Outputs: RAM command straight from the granted request, zeroed when idle
  always_comb begin : drive_outputs
    bus.req_ready  = gnt_oh;
    bus.ram_write  = gnt_write;
    bus.ram_addr   = '0;
    bus.ram_wben   = '0;
    bus.ram_din    = '0;
    if (accept) begin
      bus.ram_addr = gnt_addr;
      bus.ram_din  = gnt_wdata;
      if (gnt_write) begin
        bus.ram_wben = gnt_wben;
      end
    end
    // A read accepted just before reset asserts must not surface a response.
    bus.resp_valid = resp_id_q & {NREQ{reset_n}};
  end

  // RAM output already lines up with the response cycle
  assign bus.resp_rdata = bus.ram_dout;

endmodule

// File: doc/rf_arb_rr.md
Name: rf_arb_rr

Overview:
- Round-robin arbiter/sequencer that shares one single-port byte-enable register-file RAM (one read or write per cycle, read data one cycle after address) among NREQ requesters.
- Sits between fetch/load-store style clients and the RAM instance.
- Accepts requests with a valid/ready handshake, drives the RAM port, and routes read data back to the issuing requester one cycle later.
- Supports bounded burst (grant hold) for streaming clients.

Parameters:
- DEPTH, 8, RAM entries; address width DLG2 = $clog2(DEPTH).
- WIDTH, 32, data width in bits; must be a multiple of 8; NBYTES = WIDTH/8.
- NREQ, 2, number of requesters (2..8).
- MAXBURST, 4, max consecutive accepts granted to one requester while others wait (>=1).

Ports:
- eph1  in  1  clock; all state updates on this edge.
- reset_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  request present, per requester.
- req_ready  out  NREQ  grant, one-hot or zero; a request is accepted when valid & ready.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ x DLG2  per-requester address.
- req_wben  in  NREQ x NBYTES  per-requester byte write enables.
- req_wdata  in  NREQ x WIDTH  per-requester write data.
- resp_valid  out  NREQ  one-hot read-data-valid, pulsed one cycle after a read accept.
- resp_rdata  out  WIDTH  read data; meaningful only when resp_valid != 0.
- ram_write  out  1  RAM write strobe.
- ram_addr  out  DLG2  RAM address.
- ram_wben  out  NBYTES  RAM byte enables.
- ram_din  out  WIDTH  RAM write data.
- ram_dout  in  WIDTH  RAM read data; corresponds to the address presented in the previous cycle.

Behaviour:
- State:
  - prio pointer: DLG2-independent, $clog2(NREQ) bits.
  - owner: id of the last granted requester.
  - burst counter: $clog2(MAXBURST+1) bits.
  - resp_id: one-hot NREQ register.
- Reset (reset_n=0 at edge):
  - prio=0, owner=0, burst=0, resp_valid=0.
  - While reset_n=0, req_ready=0 and ram_write=0, so no accept occurs.
  - A read accepted in the cycle reset asserts produces no response.
- Grant (combinational, one per cycle):
  - If owner is requesting, burst<MAXBURST, and burst>0: grant owner (burst hold).
  - Otherwise grant the first requesting index searching from prio upward, mod NREQ.
  - No valid requests: req_ready=0.
  - req_ready must not depend on resp or RAM data (no combinational loops).
- On accept by requester g:
  - If g==owner and burst>0: burst<=burst+1; else burst<=1 and owner<=g.
  - prio<=(g+1) mod NREQ.
  - When burst reaches MAXBURST, the next cycle re-arbitrates from prio. Owner may win again only if no other requester is valid.
- No accept in a cycle: burst<=0 (a burst breaks on any idle cycle); prio unchanged.
- RAM drive (combinational from the granted request):
  - ram_addr = req_addr[g].
  - ram_write = req_write[g] & accept.
  - ram_wben = req_wben[g] when writing, else 0.
  - ram_din = req_wdata[g].
  - Idle: ram_addr=0, ram_write=0, ram_wben=0, ram_din=0.
  - Write with wben=0 is accepted and completes with no RAM change.
- Read latency: a read accepted in cycle N gives resp_valid[g]=1 in cycle N+1 with resp_rdata=ram_dout. resp_rdata = ram_dout always (no extra flop).
- Writes produce no response.
- Full throughput: back-to-back reads each return one cycle later; responses never stall (clients must always sink).
- Read after write to the same address in consecutive cycles returns the new data. A write in N+1 to the address read in N does not disturb the N+1 response (RAM updates at the end of N+1).

Test Plan:
- Reset, then single read: preload RAM[3]=0xDEADBEEF; req0 read addr3 in cycle 5 -> req_ready[0]=1 in cycle 5, resp_valid=2'b01, resp_rdata=0xDEADBEEF in cycle 6.
- Byte-enable write then read: req1 write addr2 wdata 0x11223344 wben 4'b0101 over old 0xAAAAAAAA -> ram_wben=0101; subsequent read gives 0xAA22AA44 with resp_valid=2'b10.
- Contention fairness (MAXBURST=1): both requesters valid for 6 cycles -> grants alternate 0,1,0,1,0,1; exactly 3 accepts each; resp_valid one-hot matches each read's issuer.
- Burst hold (MAXBURST=4): req0 continuously valid, req1 valid from the 2nd cycle -> req0 granted 4 consecutive cycles, then req1 granted; idle cycle mid-burst resets burst count to 0.
- Reset mid-operation: read accepted in cycle N, reset_n=0 in cycle N+1 -> resp_valid=0 in N+1, req_ready=0 while in reset, prio=0 on release (req0 wins a tie).
- Idle/write-only: no valid -> ram_write=0, ram_wben=0, ram_addr=0, resp_valid=0; a write accept never raises resp_valid.
